// File: rtl/car_motion_controller_pkg.sv
// Shared game definitions: road geometry and motion-controller state encoding,
// also used by graphic_car_controller and the collision logic.
package car_motion_controller_pkg;

  localparam int ROAD_WIDTH = 128;
  localparam int CAR_WIDTH  = 16;
  localparam int CAR_HEIGHT = 32;
  localparam int CAR_X_MAX  = ROAD_WIDTH - CAR_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MOVE  = 2'd1;
  localparam logic [1:0] CRASH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_MOVE  = MOVE,
    ST_CRASH = CRASH
  } state_t;

endpackage

// File: rtl/car_motion_controller_input_synchronizer.sv
// Two-flop synchronizer for a raw push-button level; clears to 0 on reset.
module input_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/car_motion_controller.sv
// Player car position controller: per-frame button-driven movement with
// hold-to-accelerate, clamping to the road, and a timed freeze after a crash.
//
//  state    | meaning
//  ST_IDLE  | no direction held, car still
//  ST_MOVE  | exactly one direction held, car stepping each frame
//  ST_CRASH | frozen, counting down frames until release
module car_motion_controller
  import car_motion_controller_pkg::*;
#(
  parameter int X_INIT       = 56,
  parameter int Y_INIT       = 200,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = CAR_X_MAX,
  parameter int HOLD_FRAMES  = 8,
  parameter int MAX_STEP     = 4,
  parameter int CRASH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       crash,
  output logic [7:0] car_position_x,
  output logic [7:0] car_position_y,
  output logic       moving,
  output logic       crashed
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int CW = $clog2(CRASH_FRAMES + 1);
  localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0]      CRASH_LOAD = CW'(CRASH_FRAMES);
  localparam logic [2:0]         STEP_MAX   = 3'(MAX_STEP);
  localparam logic signed [8:0]  X_MIN_S    = 9'(X_MIN);
  localparam logic signed [8:0]  X_MAX_S    = 9'(X_MAX);

  logic left_s, right_s;

  input_synchronizer u_sync_left (
    .clk      (clk),
    .reset    (reset),
    .async_in (btn_left),
    .sync_out (left_s)
  );

  input_synchronizer u_sync_right (
    .clk      (clk),
    .reset    (reset),
    .async_in (btn_right),
    .sync_out (right_s)
  );

  state_t          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic [2:0]      step_q, step_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [CW-1:0]   crash_cnt_q, crash_cnt_d;
  logic            dir_right_q, dir_right_d;
  logic            moving_q, moving_d;
  logic            crashed_q, crashed_d;

  logic              move_req;
  logic              same_dir;
  logic [2:0]        step_eff;
  logic [HW-1:0]     hold_eff;
  logic [8:0]        x_ext, s_ext;
  logic signed [8:0] x_sum;
  logic [7:0]        x_clamp;

  // A reversal or a fresh press starts over at step 1 for this frame's move.
  always_comb begin
    move_req = left_s ^ right_s;
    same_dir = (state_q == ST_MOVE) && (dir_right_q == right_s);
    step_eff = same_dir ? step_q : 3'd1;
    hold_eff = same_dir ? hold_q : '0;
    x_ext    = {1'b0, x_q};
    s_ext    = {6'd0, step_eff};
    x_sum    = right_s ? $signed(x_ext + s_ext) : $signed(x_ext - s_ext);
    if (x_sum < X_MIN_S)      x_clamp = X_MIN_S[7:0];
    else if (x_sum > X_MAX_S) x_clamp = X_MAX_S[7:0];
    else                      x_clamp = x_sum[7:0];
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    step_d      = step_q;
    hold_d      = hold_q;
    crash_cnt_d = crash_cnt_q;
    dir_right_d = dir_right_q;
    moving_d    = moving_q;
    crashed_d   = crashed_q;

    unique case (state_q)
      ST_IDLE, ST_MOVE: begin
        if (crash) begin
          state_d     = ST_CRASH;
          crash_cnt_d = CRASH_LOAD;
          step_d      = 3'd1;
          hold_d      = '0;
          moving_d    = 1'b0;
          crashed_d   = 1'b1;
        end else if (frame_tick) begin
          if (!move_req) begin
            state_d  = ST_IDLE;
            step_d   = 3'd1;
            hold_d   = '0;
            moving_d = 1'b0;
          end else begin
            state_d     = ST_MOVE;
            dir_right_d = right_s;
            x_d         = x_clamp;
            moving_d    = (x_clamp != x_q);
            if (hold_eff == HOLD_LAST) begin
              hold_d = '0;
              step_d = (step_eff >= STEP_MAX) ? STEP_MAX : step_eff + 3'd1;
            end else begin
              hold_d = hold_eff + 1'b1;
              step_d = step_eff;
            end
          end
        end
      end
      ST_CRASH: begin
        if (frame_tick) begin
          if (crash_cnt_q <= CW'(1)) begin
            state_d     = ST_IDLE;
            crash_cnt_d = '0;
            crashed_d   = 1'b0;
            moving_d    = 1'b0;
          end else begin
            crash_cnt_d = crash_cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= 8'(X_INIT);
      step_q      <= 3'd1;
      hold_q      <= '0;
      crash_cnt_q <= '0;
      dir_right_q <= 1'b0;
      moving_q    <= 1'b0;
      crashed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      crash_cnt_q <= crash_cnt_d;
      dir_right_q <= dir_right_d;
      moving_q    <= moving_d;
      crashed_q   <= crashed_d;
    end
  end

  assign car_position_x = x_q;
  assign car_position_y = 8'(Y_INIT);
  assign moving         = moving_q;
  assign crashed        = crashed_q;

endmodule

// File: tb/tb_car_motion_controller.sv
// Bench for car_motion_controller: frame-level behavioural model checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_car_motion_controller;

  localparam int X_INIT = 56, Y_INIT = 200, X_MIN = 0, X_MAX = 112;
  localparam int HOLD_FRAMES = 8, MAX_STEP = 4, CRASH_FRAMES = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       crash = 1'b0;
  logic [7:0] car_position_x, car_position_y;
  logic       moving, crashed;

  int total = 0;
  int bad = 0;
  bit run_chk = 0;

  car_motion_controller dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .crash          (crash),
    .car_position_x (car_position_x),
    .car_position_y (car_position_y),
    .moving         (moving),
    .crashed        (crashed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: buttons seen two edges late; speed = frames held at a step.
  int m_x, m_step, m_frames_at_step, m_dir, m_freeze_left;
  bit m_moving;
  bit l_hist1, l_hist2, r_hist1, r_hist2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_x = X_INIT; m_step = 1; m_frames_at_step = 0; m_dir = 0;
      m_freeze_left = 0; m_moving = 0;
      l_hist1 = 0; l_hist2 = 0; r_hist1 = 0; r_hist2 = 0;
    end else begin
      bit l, r;
      int dir, nx;
      l = l_hist2; r = r_hist2;
      if (m_freeze_left > 0) begin
        if (frame_tick) begin
          m_freeze_left--;
          m_moving = 0;
        end
      end else if (crash) begin
        m_freeze_left = CRASH_FRAMES;
        m_moving = 0; m_step = 1; m_frames_at_step = 0; m_dir = 0;
      end else if (frame_tick) begin
        dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        if (dir == 0) begin
          m_step = 1; m_frames_at_step = 0; m_moving = 0; m_dir = 0;
        end else begin
          if (dir != m_dir) begin
            m_step = 1; m_frames_at_step = 0;
          end
          nx = m_x + dir * m_step;
          if (nx < X_MIN) nx = X_MIN;
          if (nx > X_MAX) nx = X_MAX;
          m_moving = (nx != m_x);
          m_x = nx;
          m_frames_at_step++;
          if (m_frames_at_step == HOLD_FRAMES) begin
            m_frames_at_step = 0;
            if (m_step < MAX_STEP) m_step++;
          end
          m_dir = dir;
        end
      end
      l_hist2 = l_hist1; l_hist1 = btn_left;
      r_hist2 = r_hist1; r_hist1 = btn_right;
    end
  end

  always @(negedge clk) begin
    if (run_chk && !reset) begin
      chk("cyc_x", int'(car_position_x), m_x);
      chk("cyc_y", int'(car_position_y), Y_INIT);
      chk("cyc_moving", int'(moving), int'(m_moving));
      chk("cyc_crashed", int'(crashed), int'(m_freeze_left > 0));
    end
  end

  task automatic do_tick(input bit with_crash);
    repeat (3) @(posedge clk);
    #1;
    frame_tick = 1'b1;
    crash = with_crash;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    crash = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", int'(car_position_x), 56);
    chk("rst_y", int'(car_position_y), 200);
    chk("rst_moving", int'(moving), 0);
    chk("rst_crashed", int'(crashed), 0);
    reset = 1'b0;
    run_chk = 1;

    // acceleration: 20 frames right from 56
    btn_right = 1'b1;
    ticks(20);
    chk("accel_x", int'(car_position_x), 92);
    chk("accel_model_x", m_x, 92);
    chk("accel_moving", int'(moving), 1);
    btn_right = 1'b0;
    ticks(1);
    chk("release_moving", int'(moving), 0);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_x", int'(car_position_x), 56);
    chk("arst_moving", int'(moving), 0);
    chk("arst_crashed", int'(crashed), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // reach x=3 at step 4, then clamp at 0
    btn_right = 1'b1;
    ticks(3);
    chk("tap_x", int'(car_position_x), 59);
    btn_right = 1'b0;
    ticks(1);
    btn_left = 1'b1;
    ticks(24);
    chk("left24_x", int'(car_position_x), 11);
    ticks(2);
    chk("left26_x", int'(car_position_x), 3);
    ticks(1);
    chk("clamp_x", int'(car_position_x), 0);
    chk("clamp_moving", int'(moving), 1);
    ticks(2);
    chk("pinned_x", int'(car_position_x), 0);
    chk("pinned_moving", int'(moving), 0);

    // both buttons, then release left
    btn_right = 1'b1;
    ticks(5);
    chk("both_x", int'(car_position_x), 0);
    chk("both_moving", int'(moving), 0);
    btn_left = 1'b0;
    ticks(1);
    chk("resume_x", int'(car_position_x), 1);
    chk("resume_moving", int'(moving), 1);
    ticks(2);
    chk("pre_crash_x", int'(car_position_x), 3);

    // crash coinciding with a tick while moving right
    do_tick(1'b1);
    chk("crash_x", int'(car_position_x), 3);
    chk("crash_crashed", int'(crashed), 1);
    chk("crash_moving", int'(moving), 0);
    for (int i = 1; i <= CRASH_FRAMES; i++) begin
      do_tick(i == 30);
      if (i == 59) chk("crash59_crashed", int'(crashed), 1);
    end
    chk("crash_exit_crashed", int'(crashed), 0);
    chk("crash_exit_x", int'(car_position_x), 3);
    ticks(1);
    chk("post_crash_x", int'(car_position_x), 4);

    // one-clock button pulse right before the tick is not seen
    btn_right = 1'b0;
    ticks(1);
    repeat (3) @(posedge clk);
    #1;
    btn_left = 1'b1;
    @(posedge clk);
    #1;
    btn_left = 1'b0;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    chk("short_x", int'(car_position_x), 4);
    chk("short_moving", int'(moving), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("short_after_x", int'(car_position_x), 4);

    run_chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/car_motion_controller.md
# car_motion_controller

Upstream stage of the car renderer in the racing game's VGA pipeline. It owns the player car's position, reads the left/right push buttons, and updates the position once per video frame. It drives the `car_position_x` / `car_position_y` bytes consumed by `graphic_car_controller`. Coordinates are road-local: x is 0..127 inside the 128-pixel road column; y is screen row bits [7:0].

## Interface

**Parameters**
- `X_INIT`, 56: reset/start x (car centred on road).
- `Y_INIT`, 200: fixed y row; y never changes after reset.
- `X_MIN`, 0: leftmost legal x.
- `X_MAX`, 112: rightmost legal x (road width 128 minus car width 16).
- `HOLD_FRAMES`, 8: frames a direction must be held before step size increments.
- `MAX_STEP`, 4: maximum pixels moved per frame.
- `CRASH_FRAMES`, 60: frames the car is frozen after a crash.

**Ports**
- `clk`, input, 1: system/pixel clock; the only clock.
- `reset`, input, 1: asynchronous, active-high.
- `frame_tick`, input, 1: one-cycle pulse from the VGA sync block at start of vertical blank.
- `btn_left`, input, 1: raw asynchronous button, active-high.
- `btn_right`, input, 1: raw asynchronous button, active-high.
- `crash`, input, 1: one-cycle collision pulse from the game logic.
- `car_position_x`, output, 8: registered car left edge.
- `car_position_y`, output, 8: registered car top edge.
- `moving`, output, 1: high while the last frame update moved the car.
- `crashed`, output, 1: high while in CRASH state.

## Operation

- Each button passes through a 2-FF synchronizer. Only the synchronized levels are used.
- FSM states:
  - **IDLE**: no direction held.
  - **MOVE**: exactly one direction held.
  - **CRASH**: frozen.
- All state and position updates happen only on cycles where `frame_tick` = 1, except crash entry.
- **Direction decode at `frame_tick`:**
  - left-only gives dir = −1; right-only gives dir = +1.
  - Neither or both gives dir = 0: go to or stay in IDLE, step ← 1, hold counter ← 0, `moving` ← 0.
- **In MOVE:**
  - x_next = x + dir·step, computed in 9-bit signed arithmetic.
  - x_next is clamped to [X_MIN, X_MAX]. The position never wraps.
  - `moving` ← 1 if x actually changed. It is 0 when pinned at a bound.
  - The hold counter increments each frame. When it reaches HOLD_FRAMES−1, it resets to 0 and step ← min(step+1, MAX_STEP).
- A direction reversal (left→right directly) restarts at step 1 with hold counter 0. The move in that frame uses step 1.
- **Crash entry:** `crash` = 1 in any non-CRASH state enters CRASH on the next clock edge, independent of `frame_tick`.
  - `crashed` ← 1, `moving` ← 0.
  - Crash counter ← CRASH_FRAMES; step ← 1; hold counter ← 0.
  - x is held.
- **In CRASH:**
  - Buttons are ignored. `crash` pulses are ignored; the counter is not restarted.
  - The counter decrements on each `frame_tick`. On the tick where it reaches 0, go to IDLE and `crashed` ← 0. No movement occurs on that tick.
- `car_position_y` is constant Y_INIT.

## Timing

- **Reset values:**
  - `car_position_x` = X_INIT, `car_position_y` = Y_INIT.
  - `moving` = 0, `crashed` = 0.
  - State IDLE, step 1, counters 0, synchronizer flops 0.
- **Button latency:** 2 clocks to the synchronized level. A press must be stable at least 2 clocks before `frame_tick` to count for that frame.
- **Position latency:** the output updates on the clock edge where `frame_tick` is sampled high, i.e. visible the cycle after the tick. It stays stable through the whole active-video period.
- **Simultaneous `crash` and `frame_tick`:** crash wins. No movement that frame; CRASH is entered.
- **Reset mid-frame or mid-crash:** returns immediately to reset values. No pending movement survives.
- `frame_tick` held high for multiple cycles is out of contract. Each high cycle counts as a frame.

## Structure

- The shared game package holds:
  - road geometry constants: ROAD_WIDTH = 128, CAR_WIDTH = 16, CAR_HEIGHT = 32, with X_MAX derived from them;
  - state encoding localparams IDLE/MOVE/CRASH;
  - these are shared with `graphic_car_controller` and the collision logic.
- Sub-module `input_synchronizer`: a 2-FF synchronizer with asynchronous reset to 0, instantiated once per button.
- Counter widths:
  - hold counter: clog2(HOLD_FRAMES);
  - crash counter: clog2(CRASH_FRAMES+1);
  - step: 3 bits.

## Test plan

- **Reset:** assert `reset` mid-simulation → x = 56, y = 200, `moving` = 0, `crashed` = 0 asynchronously, before the next clock.
- **Acceleration:** hold `btn_right` for 20 frame ticks from x = 56.
  - Step is 1 for frames 1–8, 2 for 9–16, 3 for 17–20.
  - Final x = 56 + 8 + 16 + 12 = 92.
- **Bound clamp:** hold `btn_left` from x = 3 at step 4 → x = 0 with no wrap to 255. On further ticks x stays 0 and `moving` = 0.
- **Both buttons:** press both for 5 ticks → x unchanged, `moving` = 0. Releasing left then resumes moving right at step 1.
- **Crash with tick:** pulse `crash` on the same cycle as `frame_tick` while moving right.
  - x is frozen and `crashed` = 1 for 60 ticks.
  - A second crash pulse at tick 30 does not extend the freeze.
  - After 60 ticks: IDLE, `crashed` = 0.
- **Short press:** a button pulse 1 clock wide, ending 1 clock before `frame_tick` → no movement that frame.
